// File: rtl/uart_frame_parser.sv
// uart_frame_parser: pops 16-bit words from a UART receive FIFO and parses
// SYNC / LEN / payload / CSUM frames, streaming the payload over valid/ready.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   enable            allow new FIFO reads; 0 also freezes the starvation timer
//   rx_empty          FIFO empty flag
//   read_rx_data      FIFO word, valid the cycle after an enable_rx_read pulse
//   enable_rx_read    one-cycle FIFO pop strobe
//   payload_data      payload word, held while payload_valid && !payload_ready
//   payload_valid     payload_data holds an unaccepted word
//   payload_ready     consumer accepts the word
//   payload_last      marks the final payload word of a frame
//   frame_len         LEN of the most recently accepted frame
//   frame_done        one-cycle pulse: checksum matched
//   frame_error       one-cycle pulse: frame aborted
//   error_code        1 = LEN too large, 2 = bad checksum, 3 = timeout

module uart_frame_parser #(
    parameter logic [15:0] SYNC_WORD      = 16'hA55A,
    parameter int          MAX_LEN        = 256,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        rx_empty,
    input  logic [15:0] read_rx_data,
    output logic        enable_rx_read,
    output logic [15:0] payload_data,
    output logic        payload_valid,
    input  logic        payload_ready,
    output logic        payload_last,
    output logic [15:0] frame_len,
    output logic        frame_done,
    output logic        frame_error,
    output logic [1:0]  error_code
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] MAX_W = 16'(MAX_LEN);

    typedef enum logic [1:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CSUM
    } state_t;

    state_t state;
    state_t state_next;

    logic          run;
    logic          in_flight;
    logic [15:0]   sum;
    logic [15:0]   remaining;
    logic [TW-1:0] timer;

    logic needs_word;
    logic accept;
    logic cap;
    logic len_bad;
    logic csum_ok;
    logic starve;
    logic expire;

    // A word is captured exactly one cycle after its pop strobe.
    assign cap     = in_flight;
    assign accept  = payload_valid & payload_ready;
    assign len_bad = read_rx_data > MAX_W;
    assign csum_ok = read_rx_data == sum;

    // Starvation only counts while the parser actually wants a word, so
    // consumer backpressure never advances the timer.
    assign starve = (state != HUNT) & needs_word & enable
                  & rx_empty & ~in_flight;
    assign expire = starve & (timer == T_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            HUNT: begin
                if (cap && read_rx_data == SYNC_WORD) begin
                    state_next = LEN;
                end
            end
            LEN: begin
                if (cap) begin
                    if (len_bad) begin
                        state_next = HUNT;
                    end else if (read_rx_data == 16'd0) begin
                        state_next = CSUM;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                // CSUM is only fetched once the last word has left.
                if (accept && payload_last) begin
                    state_next = CSUM;
                end
            end
            CSUM: begin
                if (cap) begin
                    state_next = HUNT;
                end
            end
            default: state_next = HUNT;
        endcase
        if (expire) begin
            state_next = HUNT;
        end
    end

    always_comb begin
        needs_word = 1'b0;
        unique case (state)
            HUNT, LEN, CSUM: needs_word = 1'b1;
            PAYLOAD: begin
                needs_word = (remaining != 16'd0)
                           & (~payload_valid | payload_ready);
            end
            default: needs_word = 1'b0;
        endcase
        // run keeps the strobe low through reset and its first cycle out.
        enable_rx_read = run & enable & ~rx_empty
                       & ~in_flight & needs_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run           <= 1'b0;
            in_flight     <= 1'b0;
            sum           <= '0;
            remaining     <= '0;
            timer         <= '0;
            payload_data  <= '0;
            payload_valid <= 1'b0;
            payload_last  <= 1'b0;
            frame_len     <= '0;
            frame_done    <= 1'b0;
            frame_error   <= 1'b0;
            error_code    <= '0;
        end else begin
            run         <= 1'b1;
            in_flight   <= enable_rx_read;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;

            if (accept) begin
                payload_valid <= 1'b0;
                payload_last  <= 1'b0;
            end

            if (cap) begin
                timer <= '0;
            end else if (expire) begin
                timer         <= '0;
                frame_error   <= 1'b1;
                error_code    <= 2'd3;
                payload_valid <= 1'b0;
                payload_last  <= 1'b0;
            end else if (starve) begin
                timer <= timer + 1'b1;
            end

            if (cap) begin
                unique case (state)
                    LEN: begin
                        if (len_bad) begin
                            frame_error <= 1'b1;
                            error_code  <= 2'd1;
                        end else begin
                            frame_len <= read_rx_data;
                            sum       <= read_rx_data;
                            remaining <= read_rx_data;
                        end
                    end
                    PAYLOAD: begin
                        payload_data  <= read_rx_data;
                        payload_valid <= 1'b1;
                        payload_last  <= remaining == 16'd1;
                        sum           <= sum + read_rx_data;
                        remaining     <= remaining - 16'd1;
                    end
                    CSUM: begin
                        if (csum_ok) begin
                            frame_done <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                            error_code  <= 2'd2;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: scoreboard bench for uart_frame_parser; a frame-level
// reference model predicts payload words and end-of-frame events.

module tb_uart_frame_parser;

    localparam logic [15:0] SYNC = 16'hA55A;
    localparam int MAX_LEN = 256;
    localparam int TMO = 100;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } pay_t;

    typedef struct {
        logic        err;
        logic [1:0]  code;
        logic [15:0] flen;
        int          idx;
    } evt_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        rx_empty;
    logic [15:0] read_rx_data;
    logic        enable_rx_read;
    logic [15:0] payload_data;
    logic        payload_valid;
    logic        payload_ready;
    logic        payload_last;
    logic [15:0] frame_len;
    logic        frame_done;
    logic        frame_error;
    logic [1:0]  error_code;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [15:0] fifo_q[$];
    logic [15:0] pbuf[$];
    pay_t        exp_pay[$];
    evt_t        exp_evt[$];
    int          pay_total = 0;
    int          pay_seen = 0;
    logic [15:0] m_flen = 16'd0;
    logic [1:0]  m_code = 2'd0;
    int          ready_mode = 2;
    int          en_mode = 1;
    bit          gaps_on = 1'b0;

    uart_frame_parser #(
        .SYNC_WORD(SYNC),
        .MAX_LEN(MAX_LEN),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .rx_empty(rx_empty),
        .read_rx_data(read_rx_data),
        .enable_rx_read(enable_rx_read),
        .payload_data(payload_data),
        .payload_valid(payload_valid),
        .payload_ready(payload_ready),
        .payload_last(payload_last),
        .frame_len(frame_len),
        .frame_done(frame_done),
        .frame_error(frame_error),
        .error_code(error_code)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // FIFO: a strobe seen mid-cycle pops at the next edge; the word is
    // presented for the whole following cycle.
    initial begin
        bit pop;
        rx_empty = 1'b1;
        read_rx_data = 16'h0;
        forever begin
            @(negedge clk);
            pop = enable_rx_read && !reset;
            if (enable_rx_read) begin
                chk("pop_while_empty", 32'(rx_empty), 32'd0);
            end
            @(posedge clk);
            #1;
            if (pop && fifo_q.size() > 0) begin
                read_rx_data = fifo_q.pop_front();
            end
            rx_empty = (fifo_q.size() == 0)
                    || (gaps_on && $urandom_range(0, 3) == 0);
        end
    end

    initial begin
        payload_ready = 1'b0;
        enable = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: payload_ready = $urandom_range(0, 9) < 7;
                1: payload_ready = 1'b0;
                default: payload_ready = 1'b1;
            endcase
            enable = (en_mode == 0) ? ($urandom_range(0, 9) != 0) : 1'b1;
        end
    end

    // Monitor: handshakes pop expected payload, pulses pop expected events.
    initial begin
        logic        hold;
        logic [15:0] held;
        pay_t        p;
        evt_t        e;
        hold = 1'b0;
        held = 16'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold = 1'b0;
            end else begin
                if (frame_done || frame_error) begin
                    chk("done_and_error", 32'(frame_done & frame_error), 32'd0);
                end
                if (hold && payload_valid) begin
                    chk("held_data", 32'(payload_data), 32'(held));
                end
                if (payload_valid && !payload_ready) begin
                    chk("read_under_backpressure", 32'(enable_rx_read), 32'd0);
                end
                if (payload_valid && payload_ready) begin
                    if (exp_pay.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_payload: got %h, expected none",
                                 payload_data);
                    end else begin
                        p = exp_pay.pop_front();
                        chk("payload_data", 32'(payload_data), 32'(p.data));
                        chk("payload_last", 32'(payload_last), 32'(p.last));
                    end
                    pay_seen++;
                end
                if (frame_done || frame_error) begin
                    if (exp_evt.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_event: done=%0d error=%0d code=%0d, expected none",
                                 frame_done, frame_error, error_code);
                    end else begin
                        e = exp_evt.pop_front();
                        chk("event_is_error", 32'(frame_error), 32'(e.err));
                        chk("error_code", 32'(error_code), 32'(e.code));
                        chk("frame_len", 32'(frame_len), 32'(e.flen));
                        chk("event_after_payload", 32'(pay_seen), 32'(e.idx));
                    end
                end
                hold = payload_valid && !payload_ready;
                held = payload_data;
            end
        end
    end

    // Frame-level model: checksum is LEN plus every payload word, mod 2^16.
    task automatic send_frame(input logic [15:0] len, input logic [15:0] bad);
        logic [15:0] s;
        pay_t p;
        evt_t e;
        fifo_q.push_back(SYNC);
        fifo_q.push_back(len);
        if (int'(len) > MAX_LEN) begin
            m_code = 2'd1;
            e.err = 1'b1;
            e.code = 2'd1;
            e.flen = m_flen;
            e.idx = pay_total;
            exp_evt.push_back(e);
        end else begin
            s = len;
            for (int i = 0; i < int'(len); i++) begin
                fifo_q.push_back(pbuf[i]);
                s = s + pbuf[i];
                p.data = pbuf[i];
                p.last = (i == int'(len) - 1);
                exp_pay.push_back(p);
                pay_total++;
            end
            fifo_q.push_back(s ^ bad);
            m_flen = len;
            if (bad == 16'h0) begin
                e.err = 1'b0;
                e.code = m_code;
            end else begin
                m_code = 2'd2;
                e.err = 1'b1;
                e.code = 2'd2;
            end
            e.flen = m_flen;
            e.idx = pay_total;
            exp_evt.push_back(e);
        end
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_pay.size() != 0
                || exp_evt.size() != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n >= bound), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_rd"}, 32'(enable_rx_read), 32'd0);
        chk({tag, "_valid"}, 32'(payload_valid), 32'd0);
        chk({tag, "_last"}, 32'(payload_last), 32'd0);
        chk({tag, "_data"}, 32'(payload_data), 32'd0);
        chk({tag, "_len"}, 32'(frame_len), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_error"}, 32'(frame_error), 32'd0);
        chk({tag, "_code"}, 32'(error_code), 32'd0);
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] len;
        logic [15:0] bad;
        pay_t p;
        evt_t e;
        int n;
        int t0;
        int k;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        pbuf = {16'h0001, 16'h0002, 16'h0003};
        send_frame(16'd3, 16'h0);
        drain(2000);
        chk("normal_frame_len", 32'(frame_len), 32'd3);

        fifo_q.push_back(16'h1234);
        fifo_q.push_back(16'h0000);
        pbuf.delete();
        send_frame(16'd0, 16'h0);
        drain(2000);

        send_frame(16'h0101, 16'h0);
        pbuf = {16'h00FF};
        send_frame(16'd1, 16'h0);
        drain(2000);

        pbuf = {16'h0001, 16'h0002, 16'h0003};
        send_frame(16'd3, 16'h0001);
        drain(2000);

        en_mode = 0;
        ready_mode = 0;
        gaps_on = 1'b1;
        for (int f = 0; f < 40; f++) begin
            k = int'($urandom_range(0, 9));
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                w = 16'($urandom);
                if (w == SYNC) w = 16'h0;
                fifo_q.push_back(w);
            end
            if (k == 0) begin
                send_frame(16'(MAX_LEN + 1 + int'($urandom_range(0, 1000))),
                           16'h0);
            end else begin
                if (f == 7) len = 16'(MAX_LEN);
                else if (f == 13) len = 16'd0;
                else len = 16'($urandom_range(0, 6));
                pbuf.delete();
                for (int i = 0; i < int'(len); i++) begin
                    w = 16'($urandom);
                    if ($urandom_range(0, 9) == 0) w = SYNC;
                    pbuf.push_back(w);
                end
                bad = (k == 1) ? 16'($urandom_range(1, 65535)) : 16'h0;
                send_frame(len, bad);
            end
        end
        drain(60000);

        en_mode = 1;
        ready_mode = 1;
        gaps_on = 1'b0;
        pbuf = {16'h0001, 16'h0002, 16'h0003};
        send_frame(16'd3, 16'h0);
        n = 0;
        while (!payload_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bp_word_arrived", 32'(n < 200), 32'd1);
        repeat (500) @(negedge clk);
        chk("bp_valid_held", 32'(payload_valid), 32'd1);
        chk("bp_data_held", 32'(payload_data), 32'h0001);
        chk("bp_no_more_reads", 32'(fifo_q.size()), 32'd3);
        ready_mode = 2;
        drain(2000);

        p.data = 16'h0001;
        p.last = 1'b0;
        exp_pay.push_back(p);
        pay_total++;
        m_flen = 16'd2;
        m_code = 2'd3;
        e.err = 1'b1;
        e.code = 2'd3;
        e.flen = 16'd2;
        e.idx = pay_total;
        exp_evt.push_back(e);
        fifo_q.push_back(SYNC);
        fifo_q.push_back(16'd2);
        fifo_q.push_back(16'h0001);
        n = 0;
        while (!(payload_valid && payload_data == 16'h0001) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("starve_word_arrived", 32'(n < 300), 32'd1);
        t0 = cyc;
        n = 0;
        while (!frame_error && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", 32'(cyc - t0), 32'(TMO));
        drain(2000);

        ready_mode = 1;
        fifo_q.push_back(SYNC);
        fifo_q.push_back(16'd3);
        fifo_q.push_back(16'h0001);
        fifo_q.push_back(16'h0002);
        n = 0;
        while (!payload_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_word_arrived", 32'(n < 200), 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_idle("async_reset");
        fifo_q.delete();
        exp_pay.delete();
        exp_evt.delete();
        pay_total = 0;
        pay_seen = 0;
        m_flen = 16'd0;
        m_code = 2'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ready_mode = 2;
        pbuf = {16'h0007};
        send_frame(16'd1, 16'h0);
        drain(2000);
        chk("post_reset_len", 32'(frame_len), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
